// File: rtl/instr_decoder.sv
// Byte-stream instruction decoder for the 8-bit CPU: decodes ALU/branch/halt, tracks in-flight ALU ops, captures flags.
// Optional `define FLAGS_BYPASS_EN lets a waiting branch resolve from flags_in as the last pending op returns.

typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
} alu_opcode_t;

typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
} alu_flags_t;

module instr_decoder #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PENDING_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    input  logic             flags_valid,
    input  alu_flags_t       flags_in,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [1:0]       dec_kind,
    output alu_opcode_t      alu_op,
    output logic [1:0]       rd,
    output logic [1:0]       rs,
    output logic             use_imm,
    output logic [WIDTH-1:0] imm,
    output logic             br_taken,
    output alu_flags_t       status,
    output logic             halted
);

    localparam int unsigned PEND_W    = (PENDING_MAX < 2) ? 1 : $clog2(PENDING_MAX + 1);
    localparam logic [1:0]  KIND_ALU  = 2'd0;
    localparam logic [1:0]  KIND_BR   = 2'd1;
    localparam logic [1:0]  KIND_HALT = 2'd2;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_B1   = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [PEND_W-1:0] r_pending;
    logic [PEND_W-1:0] w_next_pending;
    logic [2:0]        r_cond;
    logic              w_byte_acc;
    logic              w_handshake;
    logic              w_alu_issue;
    logic              w_flags_dec;
    logic              w_bypass;
    logic              w_resolve;
    logic              w_out_alu;
    alu_flags_t        w_br_flags;

    function automatic logic cond_true(input logic [2:0] cond, input alu_flags_t f);
        logic res;
        res = 1'b0;
        case (cond)
            3'd0:    res = 1'b1;
            3'd1:    res = f.zero;
            3'd2:    res = !f.zero;
            3'd3:    res = f.carry;
            3'd4:    res = !f.carry;
            3'd5:    res = f.negative;
            3'd6:    res = f.overflow;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Handshakes, pending-op bookkeeping and next-state selection
    always_comb begin
        w_byte_acc   = in_valid && in_ready;
        w_handshake  = dec_valid && dec_ready;
        w_alu_issue  = w_handshake && (dec_kind == KIND_ALU);
        w_flags_dec  = flags_valid && (r_pending != '0);

        w_next_pending = r_pending;
        if (w_alu_issue && !w_flags_dec) begin
            w_next_pending = r_pending + PEND_W'(1);
        end else if (w_flags_dec && !w_alu_issue) begin
            w_next_pending = r_pending - PEND_W'(1);
        end

`ifdef FLAGS_BYPASS_EN
        w_bypass = flags_valid && (r_pending == PEND_W'(1));
`else
        w_bypass = 1'b0;
`endif
        w_resolve  = (r_state == S_WAIT) && ((r_pending == '0) || w_bypass);
        w_br_flags = w_bypass ? flags_in : status;

        // Only a HALT byte moves S_OP straight to S_OUT; every other S_OUT entry keeps the byte0 kind
        w_out_alu = (dec_kind == KIND_ALU) && (r_state != S_OP);

        w_next_state = r_state;
        case (r_state)
            S_OP: begin
                if (w_byte_acc) begin
                    if (in_data[7:6] == 2'b11) begin
                        w_next_state = in_data[0] ? S_OUT : S_OP;
                    end else begin
                        w_next_state = S_B1;
                    end
                end
            end
            S_B1: begin
                if (w_byte_acc) begin
                    w_next_state = (dec_kind == KIND_BR) ? S_WAIT : S_OUT;
                end
            end
            S_WAIT: begin
                if (w_resolve) begin
                    w_next_state = S_OUT;
                end
            end
            S_OUT: begin
                if (w_handshake) begin
                    w_next_state = (dec_kind == KIND_HALT) ? S_HALT : S_OP;
                end
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_OP;
        endcase

        if (flush && (r_state != S_HALT)) begin
            w_next_state = S_OP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_OP;
            r_pending <= '0;
            r_cond    <= 3'd0;
            in_ready  <= 1'b0;
            dec_valid <= 1'b0;
            dec_kind  <= KIND_ALU;
            alu_op    <= ALU_ADD;
            rd        <= 2'd0;
            rs        <= 2'd0;
            use_imm   <= 1'b0;
            imm       <= '0;
            br_taken  <= 1'b0;
            status    <= '0;
            halted    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_next_pending;
            in_ready  <= (w_next_state == S_OP) || (w_next_state == S_B1);
            halted    <= (w_next_state == S_HALT);
            dec_valid <= (w_next_state == S_OUT) &&
                         !(w_out_alu && (w_next_pending == PEND_W'(PENDING_MAX)));

            if (flags_valid) begin
                status <= flags_in;
            end

            // Byte0 fixes the instruction kind and the fields it carries
            if ((r_state == S_OP) && w_byte_acc && !flush) begin
                case (in_data[7:6])
                    2'b00, 2'b01: begin
                        dec_kind <= KIND_ALU;
                        alu_op   <= alu_opcode_t'(in_data[5:3]);
                        rd       <= in_data[1:0];
                        rs       <= 2'd0;
                        use_imm  <= in_data[6];
                        imm      <= '0;
                        br_taken <= 1'b0;
                    end
                    2'b10: begin
                        dec_kind <= KIND_BR;
                        r_cond   <= in_data[5:3];
                        use_imm  <= 1'b0;
                        br_taken <= 1'b0;
                    end
                    default: begin
                        if (in_data[0]) begin
                            dec_kind <= KIND_HALT;
                            use_imm  <= 1'b0;
                            br_taken <= 1'b0;
                        end
                    end
                endcase
            end

            if ((r_state == S_B1) && w_byte_acc && !flush) begin
                if ((dec_kind == KIND_ALU) && !use_imm) begin
                    rs <= in_data[1:0];
                end else begin
                    imm <= in_data;
                end
            end

            if (w_resolve && !flush) begin
                br_taken <= cond_true(r_cond, w_br_flags);
            end
        end
    end

endmodule
